// File: rtl/alu_result_stage.sv
// ALU writeback stage: DEPTH-entry FIFO, 1-cycle latency, no bypass; in_ready = !full, with no path from out_ready.
// Also tracks sticky status, a saturating invalid-opcode counter and the carry fed back to the ALU.
module alu_result_stage #(
    parameter int BUS_WIDTH = 8,
    parameter int DEPTH     = 2,
    parameter int ERR_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_opcode,
    input  logic [BUS_WIDTH-1:0] in_y,
    input  logic                 in_carry_out,
    input  logic                 in_borrow,
    input  logic                 in_zero,
    input  logic                 in_parity,
    input  logic                 in_invalid_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BUS_WIDTH-1:0] out_y,
    output logic [4:0]           out_flags,
    output logic                 carry_fb,
    input  logic                 carry_clr,
    output logic [4:0]           status,
    input  logic                 status_clr,
    output logic [ERR_W-1:0]     err_cnt
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = BUS_WIDTH + 5;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
    localparam logic [4:0]       OP_ADD_CARRY = 5'd2;
    localparam logic [4:0]       OP_INC       = 5'd5;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_carry;
    logic [4:0]       r_status;
    logic [ERR_W-1:0] r_err;

    logic             w_push;
    logic             w_pop;
    logic [4:0]       w_flags;
    logic [EW-1:0]    w_head;

    assign w_flags   = {in_invalid_op, in_parity, in_zero, in_borrow, in_carry_out};
    assign in_ready  = (r_count != DEPTH_C);
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid & in_ready;
    assign w_pop     = out_valid & out_ready;
    assign w_head    = r_mem[r_rd_ptr];
    assign out_y     = w_head[BUS_WIDTH-1:0];
    assign out_flags = w_head[EW-1:BUS_WIDTH];
    assign carry_fb  = r_carry;
    assign status    = r_status;
    assign err_cnt   = r_err;

    // Storage is reset so the head reads as zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= {w_flags, in_y};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_carry <= 1'b0;
        end else if (carry_clr) begin
            r_carry <= 1'b0;
        end else if (w_push && (in_opcode == OP_ADD_CARRY || in_opcode == OP_INC)) begin
            r_carry <= in_carry_out;
        end
    end

    // A clear coinciding with a push keeps the pushed entry's contribution.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_status <= '0;
            r_err    <= '0;
        end else if (status_clr) begin
            r_status <= w_push ? w_flags : 5'b0;
            r_err    <= (w_push && in_invalid_op) ? ERR_W'(1) : '0;
        end else if (w_push) begin
            r_status <= r_status | w_flags;
            if (in_invalid_op && r_err != ERR_MAX) begin
                r_err <= r_err + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage: inputs change 1ns after the rising edge, outputs are checked at the same point.
module tb_alu_result_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [4:0] in_opcode = '0;
    logic [7:0] in_y = '0;
    logic       in_carry_out = 1'b0;
    logic       in_borrow = 1'b0;
    logic       in_zero = 1'b0;
    logic       in_parity = 1'b0;
    logic       in_invalid_op = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_y;
    logic [4:0] out_flags;
    logic       carry_fb;
    logic       carry_clr = 1'b0;
    logic [4:0] status;
    logic       status_clr = 1'b0;
    logic [3:0] err_cnt;

    int checks = 0;
    int failures = 0;

    alu_result_stage #(.BUS_WIDTH(8), .DEPTH(2), .ERR_W(4)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_y(in_y),
        .in_carry_out(in_carry_out), .in_borrow(in_borrow), .in_zero(in_zero),
        .in_parity(in_parity), .in_invalid_op(in_invalid_op),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_flags(out_flags),
        .carry_fb(carry_fb), .carry_clr(carry_clr),
        .status(status), .status_clr(status_clr), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags packing: {invalid_op, parity, zero, borrow, carry_out}
    task automatic drive(input logic vld, input logic [4:0] op, input logic [7:0] y, input logic [4:0] fl);
        in_valid      = vld;
        in_opcode     = op;
        in_y          = y;
        in_invalid_op = fl[4];
        in_parity     = fl[3];
        in_zero       = fl[2];
        in_borrow     = fl[1];
        in_carry_out  = fl[0];
    endtask

    initial begin
        #2;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_out_y", 32'(out_y), 0);
        chk("rst_out_flags", 32'(out_flags), 0);
        chk("rst_carry_fb", 32'(carry_fb), 0);
        chk("rst_status", 32'(status), 0);
        chk("rst_err_cnt", 32'(err_cnt), 0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // single push, parity of 42 is 1
        drive(1, 5'd1, 8'd42, 5'b01000);
        step();
        drive(0, 0, 0, 0);
        chk("t1_out_valid", 32'(out_valid), 1);
        chk("t1_out_y", 32'(out_y), 42);
        chk("t1_out_flags", 32'(out_flags), 32'b01000);
        chk("t1_in_ready", 32'(in_ready), 1);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("t1_drained", 32'(out_valid), 0);

        // fill, reject when full, including a same-cycle pop while full
        drive(1, 5'd0, 8'h11, 0);
        step();
        drive(1, 5'd0, 8'h22, 0);
        step();
        chk("t2_full_in_ready", 32'(in_ready), 0);
        chk("t2_head", 32'(out_y), 32'h11);
        drive(1, 5'd0, 8'h33, 0);
        step();
        chk("t2_reject_head", 32'(out_y), 32'h11);
        chk("t2_reject_ready", 32'(in_ready), 0);
        out_ready = 1'b1;
        step();
        drive(0, 0, 0, 0);
        chk("t2_pop1_head", 32'(out_y), 32'h22);
        chk("t2_pop1_valid", 32'(out_valid), 1);
        step();
        chk("t2_empty", 32'(out_valid), 0);
        out_ready = 1'b0;

        for (int r = 0; r < 5; r++) begin
            drive(1, 5'd0, 8'(8'h50 + 2 * r), 0);
            step();
            drive(1, 5'd0, 8'(8'h51 + 2 * r), 0);
            step();
            drive(0, 0, 0, 0);
            chk("wrap_full", 32'(in_ready), 0);
            chk("wrap_head_a", 32'(out_y), 32'(8'h50 + 2 * r));
            step();
            chk("wrap_hold_a", 32'(out_y), 32'(8'h50 + 2 * r));
            out_ready = 1'b1;
            step();
            chk("wrap_head_b", 32'(out_y), 32'(8'h51 + 2 * r));
            step();
            chk("wrap_empty", 32'(out_valid), 0);
            out_ready = 1'b0;
        end

        // remaining tests drain continuously so the FIFO never fills
        out_ready = 1'b1;
        drive(1, 5'd2, 8'h01, 5'b00001);
        step();
        chk("carry_add", 32'(carry_fb), 1);
        drive(1, 5'd7, 8'h02, 5'b00000);
        step();
        chk("carry_other_op", 32'(carry_fb), 1);
        drive(1, 5'd5, 8'h03, 5'b00001);
        carry_clr = 1'b1;
        step();
        carry_clr = 1'b0;
        chk("carry_clr_wins", 32'(carry_fb), 0);

        drive(0, 0, 0, 0);
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        chk("status_clr_only", 32'(status), 0);
        drive(1, 5'd0, 8'h04, 5'b00001);
        step();
        drive(1, 5'd0, 8'h05, 5'b00100);
        step();
        chk("status_sticky", 32'(status), 32'b00101);
        drive(1, 5'd0, 8'h06, 5'b00010);
        status_clr = 1'b1;
        step();
        status_clr = 1'b0;
        chk("status_clr_push", 32'(status), 32'b00010);

        for (int i = 1; i <= 17; i++) begin
            drive(1, 5'd31, 8'(i), 5'b10000);
            step();
            if (i == 1)  chk("err_first", 32'(err_cnt), 1);
            if (i == 15) chk("err_at_max", 32'(err_cnt), 15);
            if (i == 17) chk("err_saturated", 32'(err_cnt), 15);
        end
        drive(0, 0, 0, 0);
        status_clr = 1'b1;
        step();
        chk("err_clr", 32'(err_cnt), 0);
        chk("status_clr_again", 32'(status), 0);
        drive(1, 5'd31, 8'h77, 5'b10000);
        step();
        status_clr = 1'b0;
        chk("err_clr_with_push", 32'(err_cnt), 1);
        drive(0, 0, 0, 0);
        step();
        chk("drain_before_rst", 32'(out_valid), 0);

        // async reset with one entry held and a push in flight
        out_ready = 1'b0;
        drive(1, 5'd2, 8'h9a, 5'b00001);
        step();
        chk("pre_rst_carry", 32'(carry_fb), 1);
        chk("pre_rst_valid", 32'(out_valid), 1);
        drive(1, 5'd0, 8'h5b, 5'b10000);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_carry_fb", 32'(carry_fb), 0);
        chk("arst_status", 32'(status), 0);
        chk("arst_err_cnt", 32'(err_cnt), 0);
        chk("arst_out_y", 32'(out_y), 0);
        drive(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post_rst_empty", 32'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
